// File: rtl/wchb_req_arbiter.sv
// Round-robin arbiter driving one 4-phase (return-to-zero) req/ack channel into a
// WCHB pipeline from N clocked requesters; ack is double-flop synchronized.
module wchb_req_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N-1:0]           i_valid,
   input  logic [N*DW-1:0]        i_data,
   output logic [N-1:0]           o_ready,
   output logic                   o_req,
   input  logic                   i_ack,
   output logic [DW-1:0]          o_data,
   output logic [$clog2(N)-1:0]   o_grant_id,
   output logic                   o_busy,
   output logic                   o_timeout
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ_HI = 2'd1,
      REQ_LO = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            ack_meta, ack_s;
   logic [IW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            found;
   logic [IW-1:0]   winner;
   logic            req_d, tmo_d;
   logic [DW-1:0]   data_d;
   logic [IW-1:0]   gid_d;
   logic [N-1:0]    ready_d;
   logic [DW-1:0]   data_arr [N];

   for (genvar k = 0; k < N; k++) begin : g_slice
      assign data_arr[k] = i_data[k*DW +: DW];
   end

   // Two-flop synchronizer for the asynchronous ack
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ack_meta <= 1'b0;
         ack_s    <= 1'b0;
      end else begin
         ack_meta <= i_ack;
         ack_s    <= ack_meta;
      end
   end

   // Round-robin pick: first valid requester after the last one served
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         logic [IW-1:0] cand;
         cand = IW'((32'(last_q) + i) % N);
         if (!found && i_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   // Handshake sequencing, output next-values and phase watchdog
   always_comb begin
      state_d = state_q;
      req_d   = o_req;
      data_d  = o_data;
      gid_d   = o_grant_id;
      ready_d = '0;
      last_d  = last_q;
      cnt_d   = cnt_q;
      tmo_d   = o_timeout;

      unique case (state_q)
         IDLE: begin
            if (found && !ack_s) begin
               req_d   = 1'b1;
               data_d  = data_arr[winner];
               gid_d   = winner;
               state_d = REQ_HI;
            end
         end
         REQ_HI: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REQ_LO;
            end
         end
         REQ_LO: begin
            if (!ack_s) begin
               ready_d[o_grant_id] = 1'b1;
               last_d              = o_grant_id;
               state_d             = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (state_q != IDLE && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end

      // A stuck handshake cannot be aborted, so the flag only reports it
      if (TIMEOUT > 0 && 32'(cnt_q) == TIMEOUT) begin
         tmo_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         o_req      <= 1'b0;
         o_data     <= '0;
         o_grant_id <= '0;
         o_ready    <= '0;
         o_busy     <= 1'b0;
         o_timeout  <= 1'b0;
         last_q     <= IW'(N - 1);
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         o_req      <= req_d;
         o_data     <= data_d;
         o_grant_id <= gid_d;
         o_ready    <= ready_d;
         o_busy     <= (state_d != IDLE);
         o_timeout  <= tmo_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wchb_req_arbiter.sv
// Bench for wchb_req_arbiter: exact-latency sequence, table of grants scored
// through a queue, stale-ack, timeout and mid-handshake reset sequences.
module tb_wchb_req_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned IW  = 2;
   localparam int unsigned TMO = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      i_valid;
   logic [N*DW-1:0]   i_data;
   logic [N-1:0]      o_ready;
   logic              o_req;
   logic              i_ack;
   logic [DW-1:0]     o_data;
   logic [IW-1:0]     o_grant_id;
   logic              o_busy;
   logic              o_timeout;

   logic mirror_en, ack_manual, ack_mirror;

   always #5 clk = ~clk;

   // Ack source: either a 1ns mirror of req (ideal wchb_cell) or bench-driven
   initial ack_mirror = 1'b0;
   always @(o_req) ack_mirror <= #1 o_req;
   assign i_ack = mirror_en ? ack_mirror : ack_manual;

   wchb_req_arbiter #(.N(N), .DW(DW), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_data     (i_data),
      .o_ready    (o_ready),
      .o_req      (o_req),
      .i_ack      (i_ack),
      .o_data     (o_data),
      .o_grant_id (o_grant_id),
      .o_busy     (o_busy),
      .o_timeout  (o_timeout)
   );

   typedef struct {
      logic [N-1:0]  valid;
      logic [N-1:0]  exp_ready;
      logic [IW-1:0] exp_gid;
      logic [DW-1:0] exp_data;
   } vec_t;

   typedef struct {
      logic [N-1:0]  ready;
      logic [IW-1:0] gid;
      logic [DW-1:0] data;
   } exp_t;

   vec_t vecs [12];
   exp_t sb_q [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic vec_t mk(input logic [N-1:0] v, input int g);
      vec_t r;
      r.valid     = v;
      r.exp_gid   = IW'(g);
      r.exp_ready = 4'b0001 << g;
      r.exp_data  = 32'hCAFE0000 + 32'(g);
      return r;
   endfunction

   function automatic exp_t mk_exp(input int g);
      exp_t e;
      e.ready = 4'b0001 << g;
      e.gid   = IW'(g);
      e.data  = 32'hCAFE0000 + 32'(g);
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_pulse(input int budget, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (o_ready != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("ready_pulse_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_req(input logic level, input int budget);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (o_req == level) begin
            seen = 1'b1;
            break;
         end
      end
      check("wait_req_level", 64'(seen), 64'd1);
   endtask

   task automatic score(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_unexpected_pulse"}, 64'(o_ready), 64'd0);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_ready"}, 64'(o_ready), 64'(e.ready));
         check({tag, "_gid"},   64'(o_grant_id), 64'(e.gid));
         check({tag, "_data"},  64'(o_data), 64'(e.data));
      end
   endtask

   initial begin
      logic ok;
      int   cnt;

      vecs[0]  = mk(4'b1111, 3);
      vecs[1]  = mk(4'b1111, 0);
      vecs[2]  = mk(4'b1111, 1);
      vecs[3]  = mk(4'b1111, 2);
      vecs[4]  = mk(4'b1111, 3);
      vecs[5]  = mk(4'b1111, 0);
      vecs[6]  = mk(4'b0110, 1);
      vecs[7]  = mk(4'b0110, 2);
      vecs[8]  = mk(4'b0011, 0);
      vecs[9]  = mk(4'b1000, 3);
      vecs[10] = mk(4'b1001, 0);
      vecs[11] = mk(4'b1001, 3);

      rst_n      = 1'b0;
      i_valid    = '0;
      mirror_en  = 1'b1;
      ack_manual = 1'b0;
      for (int k = 0; k < N; k++) i_data[k*DW +: DW] = 32'hCAFE0000 + 32'(k);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req",     64'(o_req), 64'd0);
      check("rst_ready",   64'(o_ready), 64'd0);
      check("rst_busy",    64'(o_busy), 64'd0);
      check("rst_timeout", 64'(o_timeout), 64'd0);
      check("rst_gid",     64'(o_grant_id), 64'd0);
      rst_n = 1'b1;

      // Single request, exact cycle latency E0..E7
      @(negedge clk);
      i_valid = 4'b0100;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check($sformatf("lat_req_E%0d", k), 64'(o_req), (k < 3) ? 64'd1 : 64'd0);
         check($sformatf("lat_ready_E%0d", k), 64'(o_ready), (k == 6) ? 64'h4 : 64'd0);
         if (k == 0) begin
            check("lat_data", 64'(o_data), 64'hCAFE0002);
            check("lat_gid",  64'(o_grant_id), 64'd2);
            check("lat_busy", 64'(o_busy), 64'd1);
         end
         if (k == 6) i_valid = '0;
      end

      // Table of grants, expectations queued as each request pattern is applied
      for (int i = 0; i < 12; i++) begin
         exp_t e;
         i_valid = vecs[i].valid;
         e.ready = vecs[i].exp_ready;
         e.gid   = vecs[i].exp_gid;
         e.data  = vecs[i].exp_data;
         sb_q.push_back(e);
         wait_pulse(40, ok);
         if (ok) score($sformatf("vec%0d", i));
      end
      i_valid = '0;
      repeat (2) @(negedge clk);
      check("sb_drained", 64'(sb_q.size()), 64'd0);

      // Stale ack held high in IDLE blocks the grant
      mirror_en  = 1'b0;
      ack_manual = 1'b1;
      repeat (3) @(negedge clk);
      i_valid = 4'b0001;
      repeat (5) @(negedge clk);
      check("stale_req",  64'(o_req), 64'd0);
      check("stale_busy", 64'(o_busy), 64'd0);
      ack_manual = 1'b0;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         cnt++;
         if (o_req) break;
      end
      check("stale_latency", 64'(cnt), 64'd3);
      mirror_en = 1'b1;
      sb_q.push_back(mk_exp(0));
      wait_pulse(40, ok);
      if (ok) score("stale");
      i_valid = '0;

      // Timeout with ack held low, then the handshake completes
      @(negedge clk);
      check("tmo_clear_before", 64'(o_timeout), 64'd0);
      mirror_en  = 1'b0;
      ack_manual = 1'b0;
      i_valid    = 4'b0010;
      sb_q.push_back(mk_exp(1));
      wait_req(1'b1, 10);
      repeat (4) @(negedge clk);
      check("tmo_not_yet", 64'(o_timeout), 64'd0);
      repeat (16) @(negedge clk);
      check("tmo_set",  64'(o_timeout), 64'd1);
      check("tmo_req",  64'(o_req), 64'd1);
      check("tmo_busy", 64'(o_busy), 64'd1);
      ack_manual = 1'b1;
      wait_req(1'b0, 10);
      ack_manual = 1'b0;
      wait_pulse(40, ok);
      if (ok) score("tmo");
      i_valid = '0;
      @(negedge clk);
      check("tmo_sticky", 64'(o_timeout), 64'd1);
      mirror_en = 1'b1;

      // Reset while in REQ_HI; priority returns to requester 0
      i_valid = 4'b1111;
      wait_req(1'b1, 10);
      check("rreset_gid_before", 64'(o_grant_id), 64'd2);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rreset_req",     64'(o_req), 64'd0);
      check("rreset_busy",    64'(o_busy), 64'd0);
      check("rreset_ready",   64'(o_ready), 64'd0);
      check("rreset_gid",     64'(o_grant_id), 64'd0);
      check("rreset_timeout", 64'(o_timeout), 64'd0);
      sb_q.push_back(mk_exp(0));
      wait_pulse(40, ok);
      if (ok) score("rreset");
      i_valid = '0;
      repeat (3) @(negedge clk);
      check("final_sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
